zevensegment_scan: RTL and testbench
====================================

Name: zevensegment_scan

Overview:
- Display-side stage of the zevensegment IP, fed directly by the AXI4-Lite register block's register outputs.
- Holds a shadow copy of digit, blank, decimal-point and brightness settings, loaded only at frame boundaries so the display never tears.
- Time-multiplexes NUM_DIGITS common-anode seven-segment digits, with a blanking subslot against ghosting and 16-step PWM brightness.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SUB_CYCLES, 6250, ACLK cycles per PWM subslot (>=2); one digit slot = 16 subslots.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- enable_i  in  1  display enable (register bit).
- digits_i  in  4*NUM_DIGITS  hex nibble per digit; digit k = bits [4k+3:4k].
- blank_i  in  NUM_DIGITS  1 = digit k dark.
- dp_i  in  NUM_DIGITS  1 = decimal point k lit.
- bright_i  in  4  brightness 0 (off) .. 15.
- upd_i  in  1  one-cycle pulse from the register block on any write; requests a shadow reload.
- an_o  out  NUM_DIGITS  anode enables, active-low.
- seg_o  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp_o  out  1  decimal-point cathode, active-low.
- frame_o  out  1  one-cycle pulse on the frame-wrap cycle.
- pending_o  out  1  reload requested, not yet applied.

Behaviour:
- Reset values:
  - an_o all 1; seg_o 7'h7F; dp_o 1; frame_o 0; pending_o 1.
  - Counters 0.
  - Shadow: blank all 1, digits 0, dp 0, bright 0.
- Counters:
  - sub_cnt counts 0..SUB_CYCLES-1.
  - On sub_cnt wrap, subslot counts 0..15.
  - On subslot wrap, digit counts 0..NUM_DIGITS-1.
- Frame-wrap cycle: digit = NUM_DIGITS-1, subslot = 15, sub_cnt = SUB_CYCLES-1.
- Shadow reload:
  - On the frame-wrap cycle, if pending or upd_i, shadow loads all inputs sampled that cycle and pending clears.
  - upd_i on any other cycle sets pending.
  - upd_i on the wrap cycle itself loads that cycle's inputs; pending ends 0.
- Lit condition for the current digit: subslot != 0, AND 1 <= subslot <= shadow bright, AND shadow blank[digit] = 0, AND enable_i = 1.
  - Subslot 0 is always dark (blanking gap).
  - bright = 0 keeps the digit permanently dark.
  - bright = 15 lights subslots 1..15.
- Outputs are registered; one cycle of latency from counter state:
  - When lit: an_o has only bit[digit] = 0; seg_o = ~hex2seg(shadow digit nibble); dp_o = ~shadow dp[digit].
  - When not lit: an_o all 1, seg_o 7'h7F, dp_o 1.
- Decode (active-high gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- enable_i low:
  - Counters are held at 0 and outputs are dark on the next edge.
  - frame_o does not pulse.
  - Any upd_i loads the shadow immediately on that edge; pending clears.
- enable_i rising: scanning starts at digit 0, subslot 0. The first lit output appears at subslot 1.
- frame_o is registered: it is high the cycle after the frame-wrap cycle.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Counting resumes on the first ACLK edge after deassertion.
- Inputs other than upd_i may change at any time. They affect the display only via the shadow.

Decomposition:
- Package zevensegment_pkg:
  - Constant for subslots per slot (16).
  - Constant for the blank cathode pattern (7'h7F).
  - hex-to-segment lookup table/function.
- Sub-module zevensegment_hex2seg: combinational 4-bit to 7-bit active-high decoder. It is instantiated once and fed by the current digit's shadow nibble.

Test Plan (NUM_DIGITS=4, SUB_CYCLES=4: slot = 64 clocks, frame = 256 clocks):
- Reset + no upd_i + enable_i = 1 -> an_o stays 4'hF and frame_o pulses every 256 clocks. The first frame wrap loads the shadow (pending_o reset 1), so the display lights after it.
- digits_i = 16'h3210, bright = 15, blank = 0, upd_i pulse, wait a frame -> digit0 slot:
  - seg_o = 7'h40, an_o = 4'hE for 60 clocks after a 4-clock dark gap.
  - digit1: seg_o = 7'h79, an_o = 4'hD.
  - digit2: seg_o = 7'h24, an_o = 4'hB.
  - digit3: seg_o = 7'h30, an_o = 4'h7.
- bright = 4 -> each slot shows 16 clocks lit (subslots 1..4) and 48 dark. bright = 0 -> an_o constantly 4'hF.
- blank_i = 4'b0100, dp_i = 4'b0001 -> digit2 slot is dark; dp_o = 0 only during lit digit0 subslots.
- digits_i changed to 16'hFFFF with upd_i mid-frame -> old pattern is kept until the frame wrap and pending_o = 1 meanwhile. The new pattern (seg_o = 7'h0E) appears from the next frame and pending_o returns to 0.
- enable_i low mid-slot -> dark on the next edge. ARESETN pulsed mid-frame -> all outputs return to reset values asynchronously and pending_o = 1.

Source files
------------

// File: rtl/zevensegment_scan_pkg.sv
// Shared constants and the hex-to-segment lookup for the seven-segment
// scan stage. No ports; imported by the interface users and the decoder.
package zevensegment_pkg;

  // PWM subslots per digit slot; subslot 0 is the anti-ghosting gap.
  localparam int SUBSLOTS = 16;

  // Cathode pattern with every segment off (cathodes are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/zevensegment_scan_if.sv
// Register-side settings and display-side outputs of the scan stage.
//   master: register block / bench side (drives settings, observes display)
//   slave : zevensegment_scan
// Signals: enable_i, digits_i[4*NUM_DIGITS], blank_i, dp_i, bright_i[4],
//          upd_i, an_o[NUM_DIGITS], seg_o[7], dp_o, frame_o, pending_o.
interface zevensegment_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable_i;
  logic [4*NUM_DIGITS-1:0]   digits_i;
  logic [NUM_DIGITS-1:0]     blank_i;
  logic [NUM_DIGITS-1:0]     dp_i;
  logic [3:0]                bright_i;
  logic                      upd_i;
  logic [NUM_DIGITS-1:0]     an_o;
  logic [6:0]                seg_o;
  logic                      dp_o;
  logic                      frame_o;
  logic                      pending_o;

  modport master (
    output enable_i, digits_i, blank_i, dp_i, bright_i, upd_i,
    input  an_o, seg_o, dp_o, frame_o, pending_o
  );

  modport slave (
    input  enable_i, digits_i, blank_i, dp_i, bright_i, upd_i,
    output an_o, seg_o, dp_o, frame_o, pending_o
  );
endinterface

// File: rtl/zevensegment_scan_hex2seg.sv
// Combinational nibble decoder.
//   hex_i : 4-bit hex value
//   seg_o : active-high {g,f,e,d,c,b,a}
module zevensegment_hex2seg
  import zevensegment_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex2seg(hex_i);
endmodule

// File: rtl/zevensegment_scan.sv
// Time-multiplexed common-anode seven-segment scanner with PWM brightness.
// Settings are captured into a shadow copy only at the frame wrap (or
// immediately while disabled) so a frame is never drawn from mixed data.
//   ACLK, ARESETN : clock, async active-low reset
//   bus (slave)   : enable/digits/blank/dp/bright/upd in;
//                   an/seg/dp (active-low), frame pulse, pending out
module zevensegment_scan
  import zevensegment_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SUB_CYCLES = 6250
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  zevensegment_scan_if.slave bus
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(SUB_CYCLES);
  localparam logic [SW-1:0] LAST_SUB     = SW'(SUB_CYCLES - 1);
  localparam logic [3:0]    LAST_SUBSLOT = 4'(SUBSLOTS - 1);
  localparam logic [DW-1:0] LAST_DIGIT   = DW'(NUM_DIGITS - 1);

  // scan counters
  logic [SW-1:0] sub_cnt_q, sub_cnt_d;
  logic [3:0]    subslot_q, subslot_d;
  logic [DW-1:0] digit_q,   digit_d;

  // shadow settings
  logic [4*NUM_DIGITS-1:0] sh_dig_q;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_dp_q;
  logic [3:0]              sh_bright_q;
  logic                    pending_q, pending_d;

  // registered outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q;

  logic       en, wrap, load, lit;
  logic [3:0] nibble;
  logic [6:0] seg_hi;

  assign en   = bus.enable_i;
  assign wrap = en && (digit_q == LAST_DIGIT) && (subslot_q == LAST_SUBSLOT)
                   && (sub_cnt_q == LAST_SUB);
  // While disabled nothing is displayed, so a write can land at once.
  assign load = (!en && bus.upd_i) || (wrap && (pending_q || bus.upd_i));

  always_comb begin
    sub_cnt_d = sub_cnt_q;
    subslot_d = subslot_q;
    digit_d   = digit_q;
    if (!en) begin
      sub_cnt_d = '0;
      subslot_d = '0;
      digit_d   = '0;
    end else if (sub_cnt_q == LAST_SUB) begin
      sub_cnt_d = '0;
      subslot_d = subslot_q + 4'd1;
      if (subslot_q == LAST_SUBSLOT)
        digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + DW'(1);
    end else begin
      sub_cnt_d = sub_cnt_q + SW'(1);
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (load)            pending_d = 1'b0;
    else if (bus.upd_i)  pending_d = 1'b1;
  end

  assign nibble = sh_dig_q[{digit_q, 2'b00} +: 4];

  zevensegment_hex2seg u_hex2seg (
    .hex_i (nibble),
    .seg_o (seg_hi)
  );

  // Subslot 0 is never lit, so bright=N lights subslots 1..N.
  assign lit = en && (subslot_q != 4'd0) && (subslot_q <= sh_bright_q)
                  && !sh_blank_q[digit_q];

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(NUM_DIGITS'(1) << digit_q);
      seg_d = ~seg_hi;
      dp_d  = ~sh_dp_q[digit_q];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sub_cnt_q   <= '0;
      subslot_q   <= '0;
      digit_q     <= '0;
      sh_dig_q    <= '0;
      sh_blank_q  <= '1;
      sh_dp_q     <= '0;
      sh_bright_q <= '0;
      pending_q   <= 1'b1;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      sub_cnt_q <= sub_cnt_d;
      subslot_q <= subslot_d;
      digit_q   <= digit_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= wrap;
      if (load) begin
        sh_dig_q    <= bus.digits_i;
        sh_blank_q  <= bus.blank_i;
        sh_dp_q     <= bus.dp_i;
        sh_bright_q <= bus.bright_i;
      end
    end
  end

  assign bus.an_o      = an_q;
  assign bus.seg_o     = seg_q;
  assign bus.dp_o      = dp_q;
  assign bus.frame_o   = frame_q;
  assign bus.pending_o = pending_q;

endmodule

// File: tb/tb_zevensegment_scan.sv
module tb_zevensegment_scan;
  localparam int N     = 4;
  localparam int SC    = 4;
  localparam int SLOT  = 16 * SC;
  localparam int FRAME = N * SLOT;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [13:0] RST_OBS = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1};

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  zevensegment_scan_if #(.NUM_DIGITS(N)) bus ();
  zevensegment_scan #(.NUM_DIGITS(N), .SUB_CYCLES(SC)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model: position within the frame plus shadow settings
  int         m_pos;
  logic       m_pend;
  logic [15:0] m_dig;
  logic [3:0] m_blank, m_dp, m_bright;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_frame;

  function automatic logic [13:0] obs();
    return {bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o, bus.pending_o};
  endfunction
  function automatic logic [13:0] expv();
    return {e_an, e_seg, e_dp, e_frame, m_pend};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_pend = 1'b1; m_dig = '0; m_blank = '1; m_dp = '0; m_bright = '0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
  endtask

  // Predicts the effect of the next rising edge from the current inputs.
  task automatic model_edge();
    int d, s;
    logic lit, wrap, en, upd;
    en = bus.enable_i; upd = bus.upd_i;
    d = (m_pos / SLOT) % N;
    s = (m_pos / SC) % 16;
    lit = en && s != 0 && s <= int'(m_bright) && !m_blank[d];
    e_an  = lit ? ~(4'b0001 << d) : 4'hF;
    e_seg = lit ? ~HEX[m_dig[4*d +: 4]] : 7'h7F;
    e_dp  = lit ? ~m_dp[d] : 1'b1;
    wrap = en && (m_pos == FRAME - 1);
    e_frame = wrap;
    if ((!en && upd) || (wrap && (m_pend || upd))) begin
      m_dig = bus.digits_i; m_blank = bus.blank_i; m_dp = bus.dp_i;
      m_bright = bus.bright_i; m_pend = 1'b0;
    end else if (upd) begin
      m_pend = 1'b1;
    end
    m_pos = en ? (m_pos + 1) % FRAME : 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] bl,
                        input logic [3:0] dp, input logic [3:0] br);
    bus.digits_i = d; bus.blank_i = bl; bus.dp_i = dp; bus.bright_i = br;
  endtask

  task automatic pulse_upd();
    bus.upd_i = 1'b1; tick(); bus.upd_i = 1'b0;
  endtask

  // Advance until the model has just passed a frame wrap (bounded).
  task automatic to_frame();
    int n = 0;
    do begin tick(); n++; end while (!e_frame && n < 2 * FRAME);
    if (!e_frame) begin
      errors++; checks++;
      $display("FAIL to_frame: no frame wrap within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    int nfr = 0, first = -1, dark_bad = 0, lit_after = 0;
    bus.enable_i = 1'b1; bus.upd_i = 1'b0;
    set_in(16'h3210, 4'h0, 4'h0, 4'hF);
    #12;
    if (obs() !== RST_OBS) begin
      errors++; $display("FAIL reset_values: got %h want %h", obs(), RST_OBS);
    end
    checks++;
    @(negedge ACLK); ARESETN = 1'b1; model_reset();
    for (int i = 0; i < FRAME + 2 * SLOT; i++) begin
      tick();
      if (obs() !== expv()) begin
        errors++; $display("FAIL reset_run cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
      if (bus.frame_o) begin nfr++; if (first < 0) first = i; end
      if (i < FRAME && bus.an_o !== 4'hF) dark_bad++;
      if (i >= FRAME && bus.an_o !== 4'hF) lit_after++;
    end
    if (first !== FRAME - 1 || nfr !== 1) begin
      errors++; $display("FAIL first_frame: got idx %0d n %0d want %0d 1", first, nfr, FRAME - 1);
    end
    checks++;
    if (dark_bad !== 0) begin
      errors++; $display("FAIL dark_before_load: got %0d lit cycles want 0", dark_bad);
    end
    checks++;
    if (lit_after !== 120) begin
      errors++; $display("FAIL lit_after_load: got %0d want 120", lit_after);
    end
    checks++;
  endtask

  task automatic test_scan();
    int cnt [4];
    int gap;
    logic [3:0] an_c [4];
    logic [6:0] sg_c [4];
    an_c = '{4'hE, 4'hD, 4'hB, 4'h7};
    sg_c = '{7'h40, 7'h79, 7'h24, 7'h30};
    set_in(16'h3210, 4'h0, 4'h0, 4'hF);
    pulse_upd(); to_frame();
    cnt = '{0, 0, 0, 0}; gap = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (obs() !== expv()) begin
        errors++; $display("FAIL scan cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
      for (int k = 0; k < 4; k++)
        if (bus.an_o === an_c[k] && bus.seg_o === sg_c[k]) cnt[k]++;
      if (i < SC && bus.an_o === 4'hF) gap++;
    end
    for (int k = 0; k < 4; k++) begin
      if (cnt[k] !== 60) begin
        errors++; $display("FAIL scan_digit%0d: got %0d lit cycles want 60", k, cnt[k]);
      end
      checks++;
    end
    if (gap !== SC) begin
      errors++; $display("FAIL scan_gap: got %0d want %0d", gap, SC);
    end
    checks++;
    for (int r = 0; r < 3; r++) begin
      set_in(16'($urandom), 4'h0, 4'($urandom), 4'hF);
      pulse_upd(); to_frame();
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if (obs() !== expv()) begin
          errors++; $display("FAIL scan_rand r%0d cyc %0d: got %h want %h", r, i, obs(), expv());
        end
        checks++;
      end
    end
  endtask

  task automatic test_brightness();
    int lit;
    logic [3:0] br [3];
    br = '{4'd4, 4'd0, 4'($urandom_range(1, 15))};
    for (int r = 0; r < 3; r++) begin
      set_in(16'($urandom), 4'h0, 4'h0, br[r]);
      pulse_upd(); to_frame();
      lit = 0;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if (obs() !== expv()) begin
          errors++; $display("FAIL bright%0d cyc %0d: got %h want %h", br[r], i, obs(), expv());
        end
        checks++;
        if (bus.an_o !== 4'hF) lit++;
      end
      if (lit !== N * SC * int'(br[r])) begin
        errors++; $display("FAIL bright%0d_lit: got %0d want %0d", br[r], lit, N * SC * int'(br[r]));
      end
      checks++;
    end
  endtask

  task automatic test_blank_dp();
    int dp_lo = 0, d2 = 0, dp_bad = 0;
    set_in(16'($urandom), 4'b0100, 4'b0001, 4'hF);
    pulse_upd(); to_frame();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (obs() !== expv()) begin
        errors++; $display("FAIL blank_dp cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
      if (bus.dp_o === 1'b0) dp_lo++;
      if (bus.dp_o === 1'b0 && bus.an_o !== 4'hE) dp_bad++;
      if (bus.an_o === 4'hB) d2++;
    end
    if (dp_lo !== 60 || dp_bad !== 0) begin
      errors++; $display("FAIL dp_lit: got %0d (stray %0d) want 60 (0)", dp_lo, dp_bad);
    end
    checks++;
    if (d2 !== 0) begin
      errors++; $display("FAIL blank_digit2: got %0d lit cycles want 0", d2);
    end
    checks++;
  endtask

  task automatic test_midframe();
    int early = 0, pend_lo = 0, newc = 0, n = 0;
    set_in(16'h3210, 4'h0, 4'h0, 4'hF);
    pulse_upd(); to_frame();
    for (int i = 0; i < 100; i++) tick();
    bus.digits_i = 16'hFFFF;
    pulse_upd();
    if (bus.pending_o !== 1'b1) begin
      errors++; $display("FAIL mid_pending: got %b want 1", bus.pending_o);
    end
    checks++;
    while (!bus.frame_o && n < 2 * FRAME) begin
      tick(); n++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL mid_hold cyc %0d: got %h want %h", n, obs(), expv());
      end
      checks++;
      if (bus.seg_o === 7'h0E) early++;
      if (!bus.frame_o && bus.pending_o !== 1'b1) pend_lo++;
    end
    if (early !== 0 || pend_lo !== 0 || bus.pending_o !== 1'b0 || !bus.frame_o) begin
      errors++;
      $display("FAIL mid_wrap: got early %0d pend_lo %0d pend %b frame %b want 0 0 0 1",
               early, pend_lo, bus.pending_o, bus.frame_o);
    end
    checks++;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (obs() !== expv()) begin
        errors++; $display("FAIL mid_new cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
      if (bus.seg_o === 7'h0E) newc++;
    end
    if (newc !== 240) begin
      errors++; $display("FAIL mid_new_count: got %0d want 240", newc);
    end
    checks++;
    // write landing exactly on the wrap cycle
    n = 0;
    while (m_pos != FRAME - 1 && n < 2 * FRAME) begin tick(); n++; end
    bus.digits_i = 16'h8888;
    pulse_upd();
    if (bus.pending_o !== 1'b0 || bus.frame_o !== 1'b1) begin
      errors++; $display("FAIL wrap_upd: got pend %b frame %b want 0 1", bus.pending_o, bus.frame_o);
    end
    checks++;
    for (int i = 0; i < 2 * SC; i++) tick();
    if (bus.seg_o !== 7'h00 || bus.an_o !== 4'hE) begin
      errors++; $display("FAIL wrap_upd_seg: got %h %h want 00 e", bus.seg_o, bus.an_o);
    end
    checks++;
  endtask

  task automatic test_enable_reset();
    for (int i = 0; i < 90; i++) tick();
    bus.enable_i = 1'b0;
    tick();
    if (bus.an_o !== 4'hF || bus.seg_o !== 7'h7F || bus.dp_o !== 1'b1) begin
      errors++; $display("FAIL disable_dark: got %h %h %b want f 7f 1", bus.an_o, bus.seg_o, bus.dp_o);
    end
    checks++;
    set_in(16'($urandom), 4'h0, 4'($urandom), 4'hF);
    pulse_upd();
    if (bus.pending_o !== 1'b0) begin
      errors++; $display("FAIL disabled_load: got pending %b want 0", bus.pending_o);
    end
    checks++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs() !== expv()) begin
        errors++; $display("FAIL disabled cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    bus.enable_i = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(0, 3) == 0)
        set_in(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      bus.upd_i = ($urandom_range(0, 99) == 0);
      bus.enable_i = ($urandom_range(0, 199) != 0);
      tick();
      if (obs() !== expv()) begin
        errors++; $display("FAIL rand_run cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    bus.upd_i = 1'b0; bus.enable_i = 1'b1;
    for (int i = 0; i < 150; i++) tick();
    #3 ARESETN = 1'b0;
    #1;
    if (obs() !== RST_OBS) begin
      errors++; $display("FAIL async_reset: got %h want %h", obs(), RST_OBS);
    end
    checks++;
    model_reset();
    @(negedge ACLK); ARESETN = 1'b1;
    for (int i = 0; i < FRAME + SLOT; i++) begin
      tick();
      if (obs() !== expv()) begin
        errors++; $display("FAIL post_reset cyc %0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_brightness();
    test_blank_dp();
    test_midframe();
    test_enable_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
